// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared constants and helpers for the debouncer
package debounce_pkg;

  localparam int DB_SYNC_STAGES_DEF = 2;
  localparam int DB_STABLE_CNT_DEF  = 16;

  // Counter width: enough bits to hold STABLE_CNT-1, never narrower than one bit
  function automatic int db_cnt_w(input int stable_cnt);
    int w;
    w = $clog2(stable_cnt);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// rtl/debounce_chan.sv - one debounce channel: synchroniser, stability counter, level and edge pulses
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES = DB_SYNC_STAGES_DEF,
  parameter int STABLE_CNT  = DB_STABLE_CNT_DEF,
  parameter bit RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inp,
  input  logic tick,
  output logic outp,
  output logic rise,
  output logic fall
);

  localparam int               CNT_W   = db_cnt_w(STABLE_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   s;

  assign s = sync[SYNC_STAGES-1];

  // Synchroniser chain runs every clock, independent of tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], inp};
    end
  end

  // Count tick-qualified mismatch cycles; accept the new level once the count saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      outp <= RST_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (s == outp) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == CNT_MAX) begin
          outp <= s;
          cnt  <= '0;
          rise <= s;
          fall <= ~s;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - N independent debounce channels sharing clock, reset and tick
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = DB_SYNC_STAGES_DEF,
  parameter int STABLE_CNT  = DB_STABLE_CNT_DEF,
  parameter bit RST_VAL     = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] inp,
  input  logic          tick,
  output logic [CH-1:0] outp,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall
);

  // One self-contained channel per input bit
  for (genvar i = 0; i < CH; i++) begin : g_chan
    debounce_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .STABLE_CNT (STABLE_CNT),
      .RST_VAL    (RST_VAL)
    ) u_chan (
      .clk  (clk),
      .rst_n(rst_n),
      .inp  (inp[i]),
      .tick (tick),
      .outp (outp[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// tb/tb_debounce_multi.sv - scoreboard bench for debounce_multi
module tb_debounce_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic [3:0] inp;
  logic [3:0] outp;
  logic [3:0] rise;
  logic [3:0] fall;

  debounce_multi #(
    .CH         (4),
    .SYNC_STAGES(2),
    .STABLE_CNT (4),
    .RST_VAL    (1'b0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .inp  (inp),
    .tick (tick),
    .outp (outp),
    .rise (rise),
    .fall (fall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int         cyc;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] outp;
  } ev_t;

  ev_t q[$];
  ev_t mon_ev;
  bit  gate = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic push(input int c, input logic [3:0] r, input logic [3:0] f, input logic [3:0] o);
    ev_t x;
    x.cyc  = c;
    x.rise = r;
    x.fall = f;
    x.outp = o;
    q.push_back(x);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
    check("drain", q.size(), 0);
    q.delete();
    repeat (4) @(posedge clk);
  endtask

  // Full-rate step: new level is sampled on the next edge, accepted 2+4 edges later
  task automatic step(input logic [3:0] v, input logic [3:0] r, input logic [3:0] f, input logic [3:0] o);
    @(negedge clk);
    inp = v;
    push(cyc + 6, r, f, o);
    drain();
  endtask

  // Every pulse the DUT emits must match the head of the scoreboard
  always @(negedge clk) begin
    if ((rise | fall) != 4'b0000) begin
      if (q.size() == 0) begin
        check("unexpected_pulse", {24'd0, rise, fall}, 32'd0);
      end else begin
        mon_ev = q.pop_front();
        check("evt_cycle", mon_ev.cyc, cyc);
        check("evt_rise", rise, mon_ev.rise);
        check("evt_fall", fall, mon_ev.fall);
        check("evt_outp", outp, mon_ev.outp);
      end
    end
  end

  // Tick source: always high, or high only for edges whose number is a multiple of 4
  initial begin
    tick = 1'b1;
    forever begin
      @(negedge clk);
      tick = gate ? (((cyc + 1) % 4) == 0) : 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int e;
    int cntq;

    rst_n = 1'b0;
    inp   = 4'hF;
    repeat (3) @(negedge clk);
    check("reset_outp", outp, 4'h0);
    check("reset_rise", rise, 4'h0);
    check("reset_fall", fall, 4'h0);

    rst_n = 1'b1;
    push(cyc + 6, 4'hF, 4'h0, 4'hF);
    drain();
    check("outp_after_reset", outp, 4'hF);

    step(4'h0, 4'h0, 4'hF, 4'h0);

    step(4'b0001, 4'b0001, 4'b0000, 4'b0001);

    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      inp[1] = (k % 2) == 0;
      repeat (3) @(negedge clk);
    end
    inp[1] = 1'b1;
    push(cyc + 6, 4'b0010, 4'b0000, 4'b0011);
    drain();
    check("bounce_outp", outp, 4'b0011);

    step(4'b0111, 4'b0100, 4'b0000, 4'b0111);

    gate = 1'b1;
    repeat (8) @(negedge clk);
    inp[2] = 1'b0;
    n = cyc;
    e = n + 3;
    cntq = 0;
    while (1) begin
      if ((e % 4) == 0) cntq++;
      if (cntq == 4) break;
      e++;
    end
    push(e, 4'b0000, 4'b0100, 4'b0011);
    drain();
    gate = 1'b0;
    repeat (2) @(negedge clk);
    check("gated_outp", outp, 4'b0011);

    @(negedge clk);
    inp = 4'b1011;
    n = cyc;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_outp", outp, 4'b0000);
    check("async_rst_rise", rise, 4'b0000);
    check("async_rst_fall", fall, 4'b0000);
    rst_n = 1'b1;
    push(n + 10, 4'b1011, 4'b0000, 4'b1011);
    drain();

    step(4'b0000, 4'b0000, 4'b1011, 4'b0000);
    step(4'b1010, 4'b1010, 4'b0000, 4'b1010);
    check("final_outp", outp, 4'b1010);
    check("queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
